// File: rtl/calc_pkg.sv
// Shared operator codes and sequencer state encoding for the calculator datapath.
package calc_pkg;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/iter_muldiv.sv
// Shared iterative core: shift-add multiply and restoring divide, one step per clock.
// result/product_hi/done show the step being taken this cycle, so the caller captures them on the final edge.
module iter_muldiv #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             done,
  output logic [WIDTH-1:0] product_hi,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic             run_q;
  logic             mode_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] hi_q, lo_q, opd_q;
  logic [WIDTH-1:0] hi_d, lo_d, addend;
  logic [WIDTH:0]   sum, shifted;
  logic             fits;

  // hi:lo is the product/shift pair for mul, remainder:quotient for div
  always_comb begin
    addend  = lo_q[0] ? opd_q : '0;
    sum     = {1'b0, hi_q} + {1'b0, addend};
    shifted = {hi_q, lo_q[WIDTH-1]};
    fits    = (shifted >= {1'b0, opd_q});
    if (!mode_q) begin
      hi_d = sum[WIDTH:1];
      lo_d = {sum[0], lo_q[WIDTH-1:1]};
    end else if (fits) begin
      hi_d = shifted[WIDTH-1:0] - opd_q;
      lo_d = {lo_q[WIDTH-2:0], 1'b1};
    end else begin
      hi_d = shifted[WIDTH-1:0];
      lo_d = {lo_q[WIDTH-2:0], 1'b0};
    end
  end

  assign done       = run_q && (cnt_q == LAST);
  assign product_hi = hi_d;
  assign result     = lo_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      run_q  <= 1'b0;
      mode_q <= 1'b0;
      cnt_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      opd_q  <= '0;
    end else if (start) begin
      run_q  <= 1'b1;
      mode_q <= mode;
      cnt_q  <= '0;
      hi_q   <= '0;
      lo_q   <= operand_a;
      opd_q  <= operand_b;
    end else if (run_q) begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      cnt_q <= cnt_q + CW'(1);
      if (done) run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/exec_sequencer.sv
// Execute sequencer: single-cycle add/sub, iterative mul/div, registered result/error
// and the MS/MR/MC memory register.
module exec_sequencer
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             execute,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             MS_in,
  input  logic             MR_in,
  input  logic             MC_in,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             error,
  output logic [WIDTH-1:0] mem_value,
  output logic             mem_full,
  output logic             recall_valid
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d, mem_q, mem_d;
  logic             busy_q, busy_d, valid_q, valid_d, error_q, error_d;
  logic             full_q, full_d, recall_q, recall_d;
  logic             accept_c, b_zero_c, md_start_c, md_done_c;
  logic [WIDTH-1:0] md_hi_c, md_res_c;
  logic [WIDTH:0]   sum_c, diff_c;

  assign accept_c   = (state_q == ST_IDLE) && execute;
  assign b_zero_c   = (operand_b == '0);
  assign md_start_c = accept_c && ((op == OP_MUL) || ((op == OP_DIV) && !b_zero_c));
  assign sum_c      = {1'b0, operand_a} + {1'b0, operand_b};
  assign diff_c     = {1'b0, operand_a} - {1'b0, operand_b};

  iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (md_start_c),
    .mode       (op == OP_DIV),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .done       (md_done_c),
    .product_hi (md_hi_c),
    .result     (md_res_c)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (execute) begin
          case (op)
            OP_MUL:  state_d = ST_MUL;
            OP_DIV:  state_d = b_zero_c ? ST_DONE : ST_DIV;
            default: state_d = ST_DONE;
          endcase
        end
      end
      ST_MUL, ST_DIV: if (md_done_c) state_d = ST_DONE;
      ST_DONE:        state_d = ST_IDLE;
      default:        state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs; sub borrow is the top bit of the widened difference
  always_comb begin
    result_d = result_q;
    error_d  = error_q;
    mem_d    = mem_q;
    full_d   = full_q;
    busy_d   = (state_d != ST_IDLE);
    valid_d  = (state_d == ST_DONE);
    recall_d = MR_in && !MS_in && !MC_in;
    if (accept_c) begin
      error_d = 1'b0;
      case (op)
        OP_ADD: begin
          result_d = sum_c[WIDTH-1:0];
          error_d  = sum_c[WIDTH];
        end
        OP_SUB: begin
          result_d = diff_c[WIDTH-1:0];
          error_d  = diff_c[WIDTH];
        end
        OP_DIV: begin
          if (b_zero_c) begin
            result_d = '0;
            error_d  = 1'b1;
          end
        end
        default: ;
      endcase
    end else if (md_done_c) begin
      result_d = md_res_c;
      error_d  = (state_q == ST_MUL) && (md_hi_c != '0);
    end
    if (MC_in) begin
      mem_d  = '0;
      full_d = 1'b0;
    end else if (MS_in && !busy_q) begin
      mem_d  = result_q;
      full_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      result_q <= '0;
      error_q  <= 1'b0;
      mem_q    <= '0;
      full_q   <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      recall_q <= 1'b0;
    end else begin
      result_q <= result_d;
      error_q  <= error_d;
      mem_q    <= mem_d;
      full_q   <= full_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      recall_q <= recall_d;
    end
  end

  assign busy         = busy_q;
  assign result       = result_q;
  assign result_valid = valid_q;
  assign error        = error_q;
  assign mem_value    = mem_q;
  assign mem_full     = full_q;
  assign recall_valid = recall_q;

endmodule
